// File: rtl/burst_ram_arbiter_pkg.sv
// Shared definitions for the BurstRAM arbiter, the caches and the BurstRAM model:
// arbiter FSM state encodings and BurstRAM command codes.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_if.sv
// BurstRAM command/data bus, shared by the caches (master), the arbiter and the RAM (slave).
interface burst_ram_if #(
    parameter int AW = 4,
    parameter int DW = 64
) ();
    // A command transfers in any cycle with cmd_en & ~busy. Until then the master holds
    // cmd, addr, the first wr_data beat and data_mask stable, and keeps cmd_en high.
    // rd_data is qualified by rd_data_valid, one beat per valid cycle.
    logic              cmd;
    logic              cmd_en;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wr_data;
    logic [DW/8-1:0]   data_mask;
    logic [DW-1:0]     rd_data;
    logic              rd_data_valid;
    logic              busy;

    modport master (
        output cmd, cmd_en, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, busy
    );

    modport slave (
        input  cmd, cmd_en, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, busy
    );
endinterface

// File: rtl/burst_ram_arbiter.sv
// Two-port round-robin arbiter in front of one BurstRAM. The grant is held for a
// whole burst: one command plus RAM_BURST_DATA_COUNT data beats.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH      = 4,
    parameter int RAM_BURST_DATA_BITWIDTH = 64,
    parameter int RAM_BURST_DATA_COUNT    = 4
) (
    input  logic         clk,
    input  logic         rst,
    burst_ram_if.slave   p0,
    burst_ram_if.slave   p1,
    burst_ram_if.master  br,
    output state_t       dbg_state_o,
    output logic         dbg_owner_o,
    output logic         dbg_rr_ptr_o
);

    localparam int BEAT_W = $clog2(RAM_BURST_DATA_COUNT + 1);
    localparam logic [BEAT_W-1:0] LAST_RD = BEAT_W'(RAM_BURST_DATA_COUNT);
    localparam logic [BEAT_W-1:0] LAST_WR = BEAT_W'(RAM_BURST_DATA_COUNT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BEAT_W-1:0] beat_inc;
    logic              can_issue, grant0, grant1, sel;

    // rst gates the grant so nothing reaches the RAM while reset is held.
    assign can_issue = (state_q == ST_IDLE) & ~br.busy & ~rst;
    assign grant0    = can_issue & p0.cmd_en & (~p1.cmd_en | ~rr_q);
    assign grant1    = can_issue & p1.cmd_en & (~p0.cmd_en | rr_q);
    assign beat_inc  = beat_q + BEAT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant0 | grant1) begin
                    owner_d = grant1;
                    rr_d    = ~grant1;
                    beat_d  = '0;
                    state_d = ((grant1 ? p1.cmd : p0.cmd) == CMD_WRITE) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (br.rd_data_valid) begin
                    beat_d = beat_inc;
                    if (beat_inc == LAST_RD) state_d = ST_IDLE;
                end
            end
            // First write beat left with the command; this counts the remaining ones.
            ST_WRITE: begin
                beat_d = beat_inc;
                if (beat_inc == LAST_WR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel              = (state_q == ST_IDLE) ? grant1 : owner_q;
        br.cmd_en        = grant0 | grant1;
        br.cmd           = sel ? p1.cmd       : p0.cmd;
        br.addr          = sel ? p1.addr      : p0.addr;
        br.wr_data       = sel ? p1.wr_data   : p0.wr_data;
        br.data_mask     = sel ? p1.data_mask : p0.data_mask;
        p0.busy          = p0.cmd_en ? ~grant0 : ~can_issue;
        p1.busy          = p1.cmd_en ? ~grant1 : ~can_issue;
        p0.rd_data       = br.rd_data;
        p1.rd_data       = br.rd_data;
        p0.rd_data_valid = br.rd_data_valid & (state_q == ST_READ) & ~owner_q & ~rst;
        p1.rd_data_valid = br.rd_data_valid & (state_q == ST_READ) &  owner_q & ~rst;
    end

    assign dbg_state_o  = state_q;
    assign dbg_owner_o  = owner_q;
    assign dbg_rr_ptr_o = rr_q;

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small behavioural BurstRAM behind it.
module tb_burst_ram_arbiter;
    import burst_ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    burst_ram_if #(.AW(4), .DW(64)) p0_bus ();
    burst_ram_if #(.AW(4), .DW(64)) p1_bus ();
    burst_ram_if #(.AW(4), .DW(64)) br_bus ();

    state_t dbg_state;
    logic   dbg_owner, dbg_rr;

    burst_ram_arbiter #(
        .RAM_DEPTH_BITWIDTH(4), .RAM_BURST_DATA_BITWIDTH(64), .RAM_BURST_DATA_COUNT(4)
    ) dut (
        .clk(clk), .rst(rst), .p0(p0_bus), .p1(p1_bus), .br(br_bus),
        .dbg_state_o(dbg_state), .dbg_owner_o(dbg_owner), .dbg_rr_ptr_o(dbg_rr)
    );

    function automatic logic [63:0] init_word(int i);
        return (i == 0) ? 64'h3F5A2E14_B7C6A980 : {32'hA5A5_0000, 32'(i)};
    endfunction

    function automatic logic [63:0] wpat(int k);
        case (k)
            0: return 64'h1111_1111_1111_1111;
            1: return 64'h2222_2222_2222_2222;
            2: return 64'h3333_3333_3333_3333;
            default: return 64'h4444_4444_4444_4444;
        endcase
    endfunction

    function automatic logic [63:0] apply_mask(logic [63:0] old_w, logic [63:0] new_w, logic [7:0] m);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    // BurstRAM model: read beats start the cycle after acceptance; ignores arbiter reset.
    logic [63:0] mem [16];
    logic        loaded = 1'b0;
    logic        init_busy = 1'b1;
    logic [2:0]  rd_cnt = '0;
    logic [2:0]  wr_cnt = '0;
    logic [3:0]  rd_ptr = '0;
    logic [3:0]  wr_ptr = '0;

    assign br_bus.busy          = init_busy | (rd_cnt != 0) | (wr_cnt != 0);
    assign br_bus.rd_data_valid = (rd_cnt != 0);
    assign br_bus.rd_data       = mem[rd_ptr];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else begin
            if (rd_cnt != 0) begin
                rd_cnt <= rd_cnt - 3'd1;
                rd_ptr <= rd_ptr + 4'd1;
            end
            if (wr_cnt != 0) begin
                mem[wr_ptr] <= apply_mask(mem[wr_ptr], br_bus.wr_data, br_bus.data_mask);
                wr_cnt <= wr_cnt - 3'd1;
                wr_ptr <= wr_ptr + 4'd1;
            end
            if (br_bus.cmd_en && !br_bus.busy) begin
                if (br_bus.cmd == CMD_WRITE) begin
                    mem[br_bus.addr] <= apply_mask(mem[br_bus.addr], br_bus.wr_data, br_bus.data_mask);
                    wr_cnt <= 3'd3;
                    wr_ptr <= br_bus.addr + 4'd1;
                end else begin
                    rd_cnt <= 3'd4;
                    rd_ptr <= br_bus.addr;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(int port, logic cmd, logic [3:0] addr, logic [63:0] wd, logic en);
        if (port == 0) begin
            p0_bus.cmd = cmd; p0_bus.addr = addr; p0_bus.wr_data = wd;
            p0_bus.data_mask = 8'hFF; p0_bus.cmd_en = en;
        end else begin
            p1_bus.cmd = cmd; p1_bus.addr = addr; p1_bus.wr_data = wd;
            p1_bus.data_mask = 8'hFF; p1_bus.cmd_en = en;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic       grant_q[$];
    logic       exp_q[$];
    logic       cur_owner;
    int         n_beats, n_wrong;

    initial begin
        drive(0, CMD_READ, 4'd0, '0, 1'b0);
        drive(1, CMD_READ, 4'd0, '0, 1'b0);
        tick; tick; #1;
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        check("rst_owner", 64'(dbg_owner), 64'd0);
        check("rst_rr", 64'(dbg_rr), 64'd0);
        check("rst_p0_busy", 64'(p0_bus.busy), 64'd1);
        check("rst_p1_busy", 64'(p1_bus.busy), 64'd1);
        check("rst_cmd_en", 64'(br_bus.cmd_en), 64'd0);

        // RAM still initialising: the request must wait.
        tick;
        rst = 1'b0;
        drive(0, CMD_READ, 4'd0, '0, 1'b1);
        #1;
        check("init_cmd_en", 64'(br_bus.cmd_en), 64'd0);
        check("init_p0_busy", 64'(p0_bus.busy), 64'd1);
        tick; #1;
        check("init_cmd_en2", 64'(br_bus.cmd_en), 64'd0);
        init_busy = 1'b0;
        #1;
        check("init_grant", 64'(br_bus.cmd_en), 64'd1);
        check("init_p0_busy0", 64'(p0_bus.busy), 64'd0);
        check("init_addr", 64'(br_bus.addr), 64'd0);
        check("init_cmd", 64'(br_bus.cmd), 64'(CMD_READ));
        tick;
        p0_bus.cmd_en = 1'b0;
        #1;
        check("rd0_state", 64'(dbg_state), 64'(ST_READ));
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; #1; end
            check("rd0_p0_valid", 64'(p0_bus.rd_data_valid), 64'd1);
            check("rd0_p1_valid", 64'(p1_bus.rd_data_valid), 64'd0);
            check("rd0_data", p0_bus.rd_data, init_word(b));
        end
        tick; #1;
        check("rd0_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("rd0_rr", 64'(dbg_rr), 64'd1);

        // Port 1 write burst to address 8.
        drive(1, CMD_WRITE, 4'd8, wpat(0), 1'b1);
        #1;
        check("wr_cmd_en", 64'(br_bus.cmd_en), 64'd1);
        check("wr_cmd", 64'(br_bus.cmd), 64'(CMD_WRITE));
        check("wr_beat0", br_bus.wr_data, wpat(0));
        check("wr_p1_busy", 64'(p1_bus.busy), 64'd0);
        for (int k = 1; k < 4; k++) begin
            tick;
            p1_bus.cmd_en = 1'b0;
            p1_bus.wr_data = wpat(k);
            #1;
            check("wr_state", 64'(dbg_state), 64'(ST_WRITE));
            check("wr_beat", br_bus.wr_data, wpat(k));
            check("wr_no_cmd", 64'(br_bus.cmd_en), 64'd0);
        end
        tick; #1;
        check("wr_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("wr_rr", 64'(dbg_rr), 64'd0);

        // Simultaneous requests with rr_ptr = 0.
        drive(0, CMD_READ, 4'd0, '0, 1'b1);
        drive(1, CMD_READ, 4'd4, '0, 1'b1);
        #1;
        check("sim_p0_busy", 64'(p0_bus.busy), 64'd0);
        check("sim_p1_busy", 64'(p1_bus.busy), 64'd1);
        check("sim_addr", 64'(br_bus.addr), 64'd0);
        tick;
        p0_bus.cmd_en = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; #1; end
            check("sim_p0_valid", 64'(p0_bus.rd_data_valid), 64'd1);
            check("sim_p1_valid", 64'(p1_bus.rd_data_valid), 64'd0);
            check("sim_p1_wait", 64'(p1_bus.busy), 64'd1);
            check("sim_p0_data", p0_bus.rd_data, init_word(b));
        end
        tick; #1;
        check("sim_p1_grant", 64'(br_bus.cmd_en), 64'd1);
        check("sim_p1_busy0", 64'(p1_bus.busy), 64'd0);
        check("sim_p1_addr", 64'(br_bus.addr), 64'd4);
        tick;
        p1_bus.cmd_en = 1'b0;
        #1;
        check("sim_rr", 64'(dbg_rr), 64'd0);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; #1; end
            check("sim_p1_valid", 64'(p1_bus.rd_data_valid), 64'd1);
            check("sim_p0_quiet", 64'(p0_bus.rd_data_valid), 64'd0);
            check("sim_p1_data", p1_bus.rd_data, init_word(4 + b));
        end
        tick;

        // Read back the burst port 1 wrote.
        drive(0, CMD_READ, 4'd8, '0, 1'b1);
        #1;
        check("rb_grant", 64'(br_bus.cmd_en), 64'd1);
        tick;
        p0_bus.cmd_en = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; #1; end
            check("rb_valid", 64'(p0_bus.rd_data_valid), 64'd1);
            check("rb_data", p0_bus.rd_data, wpat(b));
        end
        tick;

        // Reset in the middle of a port 0 read burst.
        drive(0, CMD_READ, 4'd0, '0, 1'b1);
        tick;
        p0_bus.cmd_en = 1'b0;
        #1;
        check("mr_beat1", 64'(p0_bus.rd_data_valid), 64'd1);
        tick; #1;
        check("mr_beat2", 64'(p0_bus.rd_data_valid), 64'd1);
        tick;
        rst = 1'b1;
        #1;
        check("mr_rst_valid", 64'(p0_bus.rd_data_valid), 64'd0);
        check("mr_rst_busy", 64'(p0_bus.busy), 64'd1);
        check("mr_rst_ram_beat", 64'(br_bus.rd_data_valid), 64'd1);
        tick;
        rst = 1'b0;
        drive(1, CMD_READ, 4'd4, '0, 1'b1);
        #1;
        check("mr_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("mr_rr", 64'(dbg_rr), 64'd0);
        check("mr_drop_p0", 64'(p0_bus.rd_data_valid), 64'd0);
        check("mr_drop_p1", 64'(p1_bus.rd_data_valid), 64'd0);
        check("mr_p1_blocked", 64'(p1_bus.busy), 64'd1);
        check("mr_no_cmd", 64'(br_bus.cmd_en), 64'd0);
        tick; #1;
        check("mr_p1_grant", 64'(br_bus.cmd_en), 64'd1);
        check("mr_p1_busy0", 64'(p1_bus.busy), 64'd0);
        tick;
        p1_bus.cmd_en = 1'b0;
        #1;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin tick; #1; end
            check("mr_p1_valid", 64'(p1_bus.rd_data_valid), 64'd1);
        end
        tick;

        // Both ports requesting continuously for six bursts.
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        drive(0, CMD_READ, 4'd0, '0, 1'b1);
        drive(1, CMD_READ, 4'd4, '0, 1'b1);
        cur_owner = 1'b0;
        n_beats = 0;
        n_wrong = 0;
        #1;
        for (int c = 0; c < 200; c++) begin
            if (p0_bus.cmd_en && !p0_bus.busy) begin grant_q.push_back(1'b0); cur_owner = 1'b0; end
            if (p1_bus.cmd_en && !p1_bus.busy) begin grant_q.push_back(1'b1); cur_owner = 1'b1; end
            if (p0_bus.rd_data_valid) begin n_beats++; if (cur_owner != 1'b0) n_wrong++; end
            if (p1_bus.rd_data_valid) begin n_beats++; if (cur_owner != 1'b1) n_wrong++; end
            if (grant_q.size() >= 6 && n_beats >= 24) break;
            tick;
            if (grant_q.size() >= 6) begin
                p0_bus.cmd_en = 1'b0;
                p1_bus.cmd_en = 1'b0;
            end
            #1;
        end
        check("fair_grants", 64'(grant_q.size()), 64'd6);
        check("fair_beats", 64'(n_beats), 64'd24);
        check("fair_misroute", 64'(n_wrong), 64'd0);
        for (int i = 0; i < 6; i++)
            check("fair_order", (i < grant_q.size()) ? 64'(grant_q[i]) : 64'hx, 64'(exp_q[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_ram_arbiter.md
Name: burst_ram_arbiter

Overview:
- Shares one BurstRAM between two cache requesters.
  - Port 0: instruction cache.
  - Port 1: data cache (CacheData).
- Each requester port mirrors the BurstRAM interface, so a cache connects unchanged.
- Round-robin arbitration. The grant is held for a whole burst: one command plus BURST_COUNT data beats.
- Sits between the cache `br_*` wiring and the BurstRAM instance.

Parameters:
- RAM_DEPTH_BITWIDTH, 4, BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64, width of one burst beat.
- RAM_BURST_DATA_COUNT, 4, beats per burst (minimum 2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- p0_cmd  in  1  0 = read, 1 = write.
- p0_cmd_en  in  1  request; held until accepted.
- p0_addr  in  RAM_DEPTH_BITWIDTH  burst address.
- p0_wr_data  in  RAM_BURST_DATA_BITWIDTH  write beat.
- p0_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  byte mask.
- p0_rd_data  out  RAM_BURST_DATA_BITWIDTH  read beat (broadcast).
- p0_rd_data_valid  out  1  read beat valid for port 0.
- p0_busy  out  1  port 0 may not issue / is not accepted.
- p1_*  same set as p0_*, for port 1.
- br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask  out  to BurstRAM.
- br_rd_data, br_rd_data_valid, br_busy  in  from BurstRAM.

Behaviour:
- Single clock `clk`. `rst` is synchronous and active-high.
- Requester contract: once `pN_cmd_en` is raised, `cmd`, `addr`, first `wr_data` and `data_mask` stay stable and `cmd_en` stays high until a cycle with `pN_busy` = 0. Acceptance is `cmd_en & ~busy`.
- States: IDLE, READ, WRITE. Registers:
  - `owner` (1 bit).
  - `rr_ptr` (1 bit; the preferred port).
  - `beat_cnt`, width $clog2(RAM_BURST_DATA_COUNT+1).
- Grant (combinational, IDLE only):
  - can_issue = IDLE & ~br_busy.
  - grant0 = can_issue & p0_cmd_en & (~p1_cmd_en | rr_ptr==0).
  - grant1 = can_issue & p1_cmd_en & (~p0_cmd_en | rr_ptr==1).
- pN_busy = ~grantN when pN_cmd_en = 1. When pN_cmd_en = 0, pN_busy = ~can_issue.
- On grant, zero-latency pass-through:
  - `br_cmd_en` = 1 in the same cycle.
  - `br_cmd`, `br_addr`, `br_wr_data`, `br_data_mask` come from the granted port.
- On the grant edge:
  - owner ← granted port.
  - rr_ptr ← other port.
  - beat_cnt ← 0.
  - State ← READ if cmd = 0, else WRITE.
- READ:
  - `pN_rd_data_valid` = br_rd_data_valid & owner==N.
  - Each valid beat increments beat_cnt.
  - After beat RAM_BURST_DATA_COUNT → IDLE.
  - The next grant is allowed in the cycle after the last beat.
- WRITE:
  - The first beat was sent with the command.
  - The next RAM_BURST_DATA_COUNT-1 cycles mux the owner's `wr_data`/`data_mask` to the RAM, with br_cmd_en = 0.
  - beat_cnt counts them, then → IDLE.
- Outside IDLE: both pN_busy = 1 and br_cmd_en = 0.
- rd_data: `pN_rd_data` = br_rd_data for both ports, always.
- br_rd_data_valid in IDLE or WRITE is dropped: no port sees it.
- br_busy high in IDLE blocks all grants. Covers the BurstRAM init after reset.
- Reset, including mid-burst:
  - State IDLE, owner = 0, rr_ptr = 0, beat_cnt = 0.
  - Outputs during rst: br_cmd_en = 0, pN_rd_data_valid = 0, pN_busy = 1.
  - Beats still arriving after reset are dropped.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1 starting with port 0.

Decomposition:
- Shared header: state encodings (IDLE/READ/WRITE) and command codes (CMD_READ = 0, CMD_WRITE = 1), reused by the caches and the BurstRAM model.
- No sub-module. The 2-way round-robin select is inline.

Test Plan:
- BurstRAM init: br_busy high after rst. Raise p0_cmd_en read, addr 0 → no br_cmd_en until br_busy falls; then p0 accepted the same cycle.
- p0 read, addr 0 → 4 beats on p0_rd_data_valid. First beat 64'h3F5A2E14_B7C6A980 per RAM.mem. p1_rd_data_valid stays 0 throughout.
- Simultaneous p0 and p1 reads (addr 0 and 4), rr_ptr = 0:
  - p0 is granted and p1_busy holds high.
  - p1 is granted on the first IDLE cycle after p0's 4th beat.
  - rr_ptr then = 0.
- p1 write burst, addr 8: 4 beats 64'h1111…, 2222…, 3333…, 4444…, mask 8'hFF. Then p0 read, addr 8 → same 4 beats back; each write beat is on br_wr_data in consecutive cycles.
- Back-to-back requests from both ports for 6 bursts → grant order 0,1,0,1,0,1; no beat is delivered to the wrong port.
- rst asserted after 2 read beats of a p0 burst → next cycle: IDLE, p0_rd_data_valid = 0; remaining RAM beats are dropped; a fresh p1 request is granted once br_busy = 0.
